// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if
// Bundles the two requester channels and the response channel of the shared
// multiplier arbiter.
//   req0_valid/req0_ready/req0_x/req0_y : requester 0 operation channel
//   req1_valid/req1_ready/req1_x/req1_y : requester 1 operation channel
//   rsp_valid/rsp_ready/rsp_id/rsp_p    : product response channel
// Modports:
//   master : client side (drives requests, consumes responses)
//   slave  : arbiter side (accepts requests, produces responses)
interface mul_share_arb_if #(
    parameter int WIDTH = 16
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_x;
    logic [WIDTH-1:0]     req0_y;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_x;
    logic [WIDTH-1:0]     req1_y;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [2*WIDTH-1:0]   rsp_p;

    modport master (
        output req0_valid, req0_x, req0_y,
        output req1_valid, req1_x, req1_y,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req0_valid, req0_x, req0_y,
        input  req1_valid, req1_x, req1_y,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb
// Shares one combinational signed Baugh-Wooley multiplier between two
// requesters. The granted operands are registered and held for LAT cycles so
// the multiplier can be timed as a LAT-cycle multicycle path, then the
// product is registered and returned with the ID of the requester.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_share_arb_if.slave (requests in, tagged product out)
// Parameters:
//   WIDTH : operand width, product is 2*WIDTH (WIDTH >= 2)
//   LAT   : cycles in CALC before the product is captured, 1..15
// Configuration macro:
//   MUL_SHARE_ARB_RR_EN : defined -> round-robin tie break,
//                         undefined -> requester 0 always wins a tie

// Combinational signed multiplier using the modified Baugh-Wooley form:
// sign-row partial products are inverted and the constant 2^W + 2^(2W-1)
// is added, so only unsigned additions are needed.
module mul_BaughWooley #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);
    localparam int PW = 2 * WIDTH;

    // Places a single partial-product bit at its weight; the concatenation
    // keeps the bit self-determined so inversion never spreads to the pad.
    function automatic logic [PW-1:0] bit_at(input logic bv, input int pos);
        logic [PW-1:0] v;
        v = {{(PW-1){1'b0}}, bv};
        return v << pos;
    endfunction

    logic [PW-1:0] acc;

    always_comb begin
        acc = bit_at(1'b1, WIDTH) | bit_at(1'b1, PW - 1);
        for (int i = 0; i < WIDTH - 1; i++) begin
            for (int j = 0; j < WIDTH - 1; j++) begin
                acc = acc + bit_at(a[i] & b[j], i + j);
            end
            acc = acc + bit_at(~(a[i] & b[WIDTH-1]), i + WIDTH - 1);
            acc = acc + bit_at(~(a[WIDTH-1] & b[i]), i + WIDTH - 1);
        end
        acc = acc + bit_at(a[WIDTH-1] & b[WIDTH-1], PW - 2);
        p = acc;
    end
endmodule

module mul_share_arb #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input logic            clk,
    input logic            rst_n,
    mul_share_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic               id_q;
    logic [3:0]         cnt_q;
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] mul_p;
    logic               grant_valid;
    logic               grant_id;
    logic               accept;
    logic               rsp_fire;

`ifdef MUL_SHARE_ARB_RR_EN
    logic               last_id_q;
`endif

    // Grant: a lone requester always wins; a tie goes to whoever was not
    // served last (round-robin) or to requester 0 (fixed priority).
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef MUL_SHARE_ARB_RR_EN
            grant_id = ~last_id_q;
`else
            grant_id = 1'b0;
`endif
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept         = (state_q == IDLE) && grant_valid;
    assign rsp_fire       = (state_q == RESP) && bus.rsp_ready;
    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept && grant_id;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_p      = p_q;

    mul_BaughWooley #(.WIDTH(WIDTH)) u_mul (
        .a (x_q),
        .b (y_q),
        .p (mul_p)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one accept, LAT frozen cycles, then hold the
    // response until the consumer takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: if (cnt_q == 4'd0) state_d = RESP;
            RESP: if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, multicycle countdown and product capture. Operands
    // stay frozen outside IDLE so the multiplier inputs never toggle while
    // its output is being waited on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            id_q  <= 1'b0;
            cnt_q <= 4'd0;
            p_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q   <= grant_id ? bus.req1_x : bus.req0_x;
                        y_q   <= grant_id ? bus.req1_y : bus.req0_y;
                        id_q  <= grant_id;
                        cnt_q <= 4'(LAT - 1);
                    end
                end
                CALC: begin
                    if (cnt_q == 4'd0) begin
                        p_q <= mul_p;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MUL_SHARE_ARB_RR_EN
    // Priority pointer: starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_q <= 1'b1;
        end else if (rsp_fire) begin
            last_id_q <= id_q;
        end
    end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb
// Scoreboard bench for mul_share_arb. Expected products are pushed when a
// request handshake is seen and popped when the response handshakes.
// A second instance built with LAT=1 covers the short-latency case.
// Build with or without MUL_SHARE_ARB_RR_EN; the contention expectation
// follows the macro.
module tb_mul_share_arb;
    localparam int WIDTH = 16;
    localparam int LAT   = 2;

    typedef struct packed {
        logic        id;
        logic [31:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    exp_t sb0[$];
    exp_t sb1[$];
    logic id_log0[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rsp_count0 = 0;
    int   rsp_count1 = 0;
    int   ready0_cnt = 0;

    mul_share_arb_if #(.WIDTH(WIDTH)) bus  ();
    mul_share_arb_if #(.WIDTH(WIDTH)) bus1 ();

    mul_share_arb #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mul_share_arb #(.WIDTH(WIDTH), .LAT(1)) dut_lat1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] r;
        r = $signed(x) * $signed(y);
        return r;
    endfunction

    // Response monitors: compare each handshaken response with the oldest
    // expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb0.size() == 0) begin
                checkOutput("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb0.pop_front();
                checkOutput("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                checkOutput("rsp_p", 64'(bus.rsp_p), 64'(e.p));
            end
            id_log0.push_back(bus.rsp_id);
            rsp_count0++;
        end
        if (bus.req0_ready) ready0_cnt++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus1.rsp_valid && bus1.rsp_ready) begin
            if (sb1.size() == 0) begin
                checkOutput("lat1_rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb1.pop_front();
                checkOutput("lat1_rsp_id", 64'(bus1.rsp_id), 64'(e.id));
                checkOutput("lat1_rsp_p", 64'(bus1.rsp_p), 64'(e.p));
            end
            rsp_count1++;
        end
    end

    // Drive one request on the main instance and hold it until accepted.
    task automatic applyStimulus(input logic who, input logic [15:0] x,
                                 input logic [15:0] y, output int acc_cyc);
        exp_t e;
        if (!who) begin
            bus.req0_valid = 1'b1; bus.req0_x = x; bus.req0_y = y;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_x = x; bus.req1_y = y;
        end
        acc_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((!who && bus.req0_ready) || (who && bus.req1_ready)) begin
                acc_cyc = cyc;
                e.id = who;
                e.p  = model(x, y);
                sb0.push_back(e);
                break;
            end
        end
        if (acc_cyc < 0) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (!who) bus.req0_valid = 1'b0;
        else      bus.req1_valid = 1'b0;
    endtask

    task automatic waitRsp(output int seen_cyc);
        seen_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen_cyc = cyc;
                break;
            end
        end
        if (seen_cyc < 0) checkOutput("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        int k;
        for (k = 0; k < 100; k++) begin
            if (sb0.size() == 0 && sb1.size() == 0) break;
            @(negedge clk);
        end
        if (k == 100) checkOutput("drain_timeout", 64'(sb0.size() + sb1.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    logic [15:0] cx [4] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0010};
    logic [15:0] cy [4] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
    logic [31:0] cp [4] = '{32'h00000001, 32'h40000000, 32'hC0008000, 32'h00000000};

    initial begin
        int   acc;
        int   seen;
        int   r0;
        int   cnt_before;
        int   accepts;
        int   acc_cycles [3];
        exp_t e;
        logic v;
        logic exp_ids [3];

        bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
        bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
        bus.rsp_ready  = 1'b1;
        bus1.req0_valid = 1'b0; bus1.req0_x = '0; bus1.req0_y = '0;
        bus1.req1_valid = 1'b0; bus1.req1_x = '0; bus1.req1_y = '0;
        bus1.rsp_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("reset_rsp_p", 64'(bus.rsp_p), 64'd0);
        checkOutput("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single operation with latency and ready pulse width.
        r0 = ready0_cnt;
        applyStimulus(1'b0, 16'h0010, 16'h0003, acc);
        waitRsp(seen);
        checkOutput("single_latency", 64'(seen - acc), 64'(LAT + 1));
        checkOutput("single_p", 64'(bus.rsp_p), 64'h30);
        checkOutput("single_id", 64'(bus.rsp_id), 64'd0);
        waitDrain();
        checkOutput("single_ready_pulse", 64'(ready0_cnt - r0), 64'd1);

        // Signed corners.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, cx[i], cy[i], acc);
            waitRsp(seen);
            checkOutput("corner_p", 64'(bus.rsp_p), 64'(cp[i]));
            waitDrain();
        end

        // Backpressure: response held, both readies low while waiting.
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b0, 16'h1234, 16'h0002, acc);
        bus.req1_valid = 1'b1; bus.req1_x = 16'h0003; bus.req1_y = 16'h0003;
        waitRsp(seen);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("bp_valid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("bp_p", 64'(bus.rsp_p), 64'h2468);
            checkOutput("bp_id", 64'(bus.rsp_id), 64'd0);
            checkOutput("bp_readies", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_no_accept", 64'(bus.req1_ready), 64'd0);
        @(negedge clk);
        checkOutput("bp_next_accept", 64'(bus.req1_ready), 64'd1);
        if (bus.req1_ready) begin
            e.id = 1'b1;
            e.p  = model(16'h0003, 16'h0003);
            sb0.push_back(e);
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        waitDrain();

        // Reset in the middle of CALC discards the operation.
        applyStimulus(1'b0, 16'h0007, 16'h0009, acc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("midreset_rsp_p", 64'(bus.rsp_p), 64'd0);
        sb0.delete();
        cnt_before = rsp_count0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("midreset_no_rsp", 64'(rsp_count0 - cnt_before), 64'd0);

        // Contention straight after reset: both valid for three operations.
        id_log0.delete();
        bus.req0_valid = 1'b1; bus.req0_x = 16'h0005; bus.req0_y = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_x = 16'h0007; bus.req1_y = 16'h0002;
        accepts = 0;
        for (int k = 0; k < 200 && accepts < 3; k++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                e.id = 1'b0; e.p = model(16'h0005, 16'h0001);
                sb0.push_back(e); accepts++;
            end
            if (bus.req1_ready) begin
                e.id = 1'b1; e.p = model(16'h0007, 16'h0002);
                sb0.push_back(e); accepts++;
            end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checkOutput("contention_accepts", 64'(accepts), 64'd3);
        waitDrain();
`ifdef MUL_SHARE_ARB_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0};
`else
        exp_ids = '{1'b0, 1'b0, 1'b0};
`endif
        checkOutput("contention_count", 64'(id_log0.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            v = (i < id_log0.size()) ? id_log0[i] : 1'bx;
            checkOutput("contention_id", 64'(v), 64'(exp_ids[i]));
        end

        // LAT=1 instance: back-to-back requester 0 traffic.
        bus1.req0_valid = 1'b1; bus1.req0_x = 16'hFFFE; bus1.req0_y = 16'h0005;
        accepts = 0;
        for (int k = 0; k < 100 && accepts < 3; k++) begin
            @(negedge clk);
            if (bus1.req0_ready) begin
                e.id = 1'b0; e.p = 32'hFFFFFFF6;
                sb1.push_back(e);
                acc_cycles[accepts] = cyc;
                accepts++;
            end
        end
        @(posedge clk); #1;
        bus1.req0_valid = 1'b0;
        checkOutput("lat1_accepts", 64'(accepts), 64'd3);
        waitDrain();
        if (accepts == 3) begin
            checkOutput("lat1_interval_a", 64'(acc_cycles[1] - acc_cycles[0]), 64'd3);
            checkOutput("lat1_interval_b", 64'(acc_cycles[2] - acc_cycles[1]), 64'd3);
        end
        checkOutput("lat1_rsp_count", 64'(rsp_count1), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Arbiter and sequencer that shares one signed Baugh-Wooley multiplier (`mul_BaughWooley`, instantiated internally) between two requesters. It captures the granted operands into registers and holds them stable for `LAT` cycles so the combinational multiplier can run as a multicycle path. It then returns the registered `2*WIDTH` product over a valid/ready response channel tagged with the requester ID. It sits between the multiplier datapath and any two client blocks that need multiplication.

## Interface
- `WIDTH`, 16, operand width; product is `2*WIDTH`.
- `LAT`, 2, cycles the operand registers stay in CALC before the product is captured; legal range 1..15.
- `clk` in 1: single clock; all state on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_x`, `req0_y` in WIDTH: requester 0 signed operands.
- `req1_valid`, `req1_ready`, `req1_x`, `req1_y`: same as above for requester 1.
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: consumer takes the product.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_p` out 2*WIDTH: signed product X*Y.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - Grant is computed combinationally from the two valids and the priority pointer.
  - `reqN_ready` = (state==IDLE) && grant==N. At most one ready is high; no ready is high outside IDLE.
  - On a handshake: capture x/y into the operand registers and the ID into `id_q`, load the down-counter with `LAT-1`, go to CALC.
- **CALC**
  - Operand registers are frozen and drive the multiplier.
  - When the counter reaches 0: register the multiplier output into `rsp_p`, set `rsp_valid`, go to RESP. Otherwise decrement.
- **RESP**
  - `rsp_valid`=1. `rsp_p` and `rsp_id` are held stable until `rsp_valid && rsp_ready`.
  - On the response handshake: clear `rsp_valid`, update the pointer, go to IDLE. `rsp_p` keeps its last value.
- Arithmetic: two's complement, full-precision `2*WIDTH` product, no overflow or truncation.
- Requester valids seen outside IDLE are ignored; the requester must hold valid and operands until its ready pulse.
- Reset mid-operation: any captured operation is discarded with no response. All state returns to reset values.
- Reset values:
  - state = IDLE, `rsp_valid` = 0, `rsp_p` = 0, `rsp_id` = 0.
  - Operand registers = 0, counter = 0.
  - Priority pointer `last_id` = 1, so requester 0 wins the first tie.

## Timing
- The request handshake at edge E0 yields `rsp_valid` high in the cycle after edge E0+LAT.
  - Example: `LAT`=2 gives 3 cycles from the accept cycle to `rsp_valid`.
- Minimum issue interval is `LAT`+2 cycles: 1 IDLE cycle, `LAT` CALC cycles, and at least 1 RESP cycle.
- A new request cannot be accepted in the cycle the response handshakes; the earliest accept is the following cycle, in IDLE.
- `req*_ready` depends combinationally on `req*_valid` (grant logic). No other combinational input-to-output path exists.
- The `mul_BaughWooley` path is a `LAT`-cycle multicycle path from the operand registers to `rsp_p`.

## Configuration
- Macro: `MUL_SHARE_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - When both requesters are valid in IDLE, grant goes to `!last_id`.
  - `last_id` is set to `rsp_id` on each response handshake.
- Not defined: fixed priority; requester 0 always wins a tie. `last_id` logic is removed.
- Single-requester behaviour is identical in both builds.

## Test plan
- **Single op:** `req0` x=0x0010, y=0x0003, `LAT`=2, `rsp_ready`=1 → `rsp_valid` 3 cycles after accept, `rsp_p`=0x00000030, `rsp_id`=0, `req0_ready` pulses for exactly one cycle.
- **Signed corners:**
  - -1 × -1 → 0x00000001.
  - 0x8000 × 0x8000 → 0x40000000.
  - 0x8000 × 0x7FFF → 0xC0008000.
  - 0x0010 × 0 → 0.
- **Contention:** both valid continuously for three operations, req0 y=1 and req1 y=2.
  - With `MUL_SHARE_ARB_RR_EN`: `rsp_id` sequence 0,1,0.
  - Without it: 0,0,0 with `req1_ready` never high.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_p`/`rsp_id` stable, both `req*_ready`=0. Release → IDLE the next cycle, next accept one cycle later.
- **Reset mid-CALC:** assert `rst_n`=0 one cycle after accept → `rsp_valid`=0 and `rsp_p`=0 immediately (asynchronous), no response after release, and the next request completes normally with requester 0 winning a tie.
- **`LAT`=1 build:** x=0xFFFE (-2), y=0x0005 → `rsp_p`=0xFFFFFFF6, with a minimum issue interval of 3 cycles under back-to-back `req0` traffic.
